// File: rtl/sub_b_dec.sv
// Receive-side decoder for the sub_b XOR frame format (b, s1=a^b, s2=b^c, p=a^c).
// Recovers a/b/c, flags parity errors and buffers frames in a FWFT FIFO.
module sub_b_dec #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sdi,
    input  logic         sdi_vld,
    input  logic         sdi_sof,
    output logic [W-1:0] dout_a,
    output logic [W-1:0] dout_b,
    output logic [W-1:0] dout_c,
    output logic         dout_err,
    output logic         dout_vld,
    input  logic         dout_rdy,
    output logic         err_sync,
    output logic         ovf,
    output logic [7:0]   ovf_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = 3 * W + 1;

    typedef enum logic [1:0] {IDLE, GET_S1, GET_S2, GET_P} state_t;

    state_t        state, state_nxt;
    logic          cap_b, cap_s1, cap_s2, push, abort;
    logic [W-1:0]  b_q, s1_q, s2_q;
    logic [FW-1:0] frame;
    logic [FW-1:0] mem [DEPTH];
    logic [FW-1:0] mem_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, rem;
    logic          full, pop, push_ok, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Any sof restarts the frame from its anchor, whatever state we are in.
    always_comb begin
        state_nxt = state;
        cap_b     = 1'b0;
        cap_s1    = 1'b0;
        cap_s2    = 1'b0;
        push      = 1'b0;
        abort     = 1'b0;
        if (sdi_vld) begin
            if (sdi_sof) begin
                cap_b     = 1'b1;
                abort     = (state != IDLE);
                state_nxt = GET_S1;
            end else begin
                case (state)
                    GET_S1: begin
                        cap_s1    = 1'b1;
                        state_nxt = GET_S2;
                    end
                    GET_S2: begin
                        cap_s2    = 1'b1;
                        state_nxt = GET_P;
                    end
                    GET_P: begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q  <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (cap_b)  b_q  <= sdi;
            if (cap_s1) s1_q <= sdi;
            if (cap_s2) s2_q <= sdi;
        end
    end

    assign frame = {s1_q ^ b_q, b_q, s2_q ^ b_q, |(sdi ^ s1_q ^ s2_q)};

    assign full     = (count == CW'(DEPTH));
    assign dout_vld = (count != '0);
    assign pop      = dout_vld & dout_rdy;
    assign push_ok  = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign rem      = count - CW'(pop);
    assign mem_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= frame;
    end

    // Head registers: refill from the incoming frame when the FIFO drains to
    // empty in the same cycle, otherwise from the next stored entry on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_a   <= '0;
            dout_b   <= '0;
            dout_c   <= '0;
            dout_err <= 1'b0;
            err_sync <= 1'b0;
            ovf      <= 1'b0;
            ovf_cnt  <= '0;
        end else begin
            err_sync <= abort;
            ovf      <= drop;
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
            if (push_ok && rem == '0)
                {dout_a, dout_b, dout_c, dout_err} <= frame;
            else if (pop && count > CW'(1))
                {dout_a, dout_b, dout_c, dout_err} <= mem_next;
        end
    end

endmodule

// File: tb/tb_sub_b_dec.sv
// Directed scoreboard bench for sub_b_dec (W=1, DEPTH=4).
module tb_sub_b_dec;

    localparam int W     = 1;
    localparam int DEPTH = 4;
    localparam int FW    = 3 * W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sdi = '0;
    logic         sdi_vld = 1'b0;
    logic         sdi_sof = 1'b0;
    logic [W-1:0] dout_a, dout_b, dout_c;
    logic         dout_err, dout_vld;
    logic         dout_rdy = 1'b0;
    logic         err_sync, ovf;
    logic [7:0]   ovf_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int err_seen    = 0;
    int ovf_seen    = 0;
    logic [FW-1:0] sb [$];

    sub_b_dec #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sdi(sdi), .sdi_vld(sdi_vld), .sdi_sof(sdi_sof),
        .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c), .dout_err(dout_err),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .err_sync(err_sync),
        .ovf(ovf), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output side: a head accepted at the coming posedge is compared here.
    always @(negedge clk) begin
        if (err_sync) err_seen++;
        if (ovf)      ovf_seen++;
        if (!rst && dout_vld && dout_rdy) begin
            if (sb.size() == 0) chk("unexpected_pop", 32'(dout_vld), 32'd0);
            else chk("pop_word", 32'({dout_a, dout_b, dout_c, dout_err}), 32'(sb.pop_front()));
        end
    end

    task automatic send_slot(input logic [W-1:0] v, input logic sof, input int gap);
        @(posedge clk); #1;
        sdi = v; sdi_sof = sof; sdi_vld = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
            sdi_vld = 1'b0; sdi_sof = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] b, input logic [W-1:0] s1,
                              input logic [W-1:0] s2, input logic [W-1:0] p,
                              input int gap, input bit exp_push, input bit rdy_at_p);
        if (exp_push) sb.push_back({s1 ^ b, b, s2 ^ b, |(p ^ s1 ^ s2)});
        send_slot(b, 1'b1, gap);
        send_slot(s1, 1'b0, gap);
        send_slot(s2, 1'b0, gap);
        send_slot(p, 1'b0, 0);
        if (rdy_at_p) dout_rdy = 1'b1;
        @(posedge clk); #1;
        sdi_vld = 1'b0; sdi_sof = 1'b0;
        if (rdy_at_p) dout_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        int budget = 40;
        dout_rdy = 1'b1;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_vld_low"}, 32'(dout_vld), 32'd0);
    endtask

    initial begin
        int e0, o0;
        #12;
        chk("rst_vld", 32'(dout_vld), 32'd0);
        chk("rst_dout", 32'({dout_a, dout_b, dout_c, dout_err}), 32'd0);
        chk("rst_ovf", 32'({err_sync, ovf, ovf_cnt}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic frame, latency of one cycle after the P slot.
        dout_rdy = 1'b1;
        send_frame(1, 0, 1, 1, 0, 1, 0);
        chk("lat_vld", 32'(dout_vld), 32'd1);
        chk("lat_word", 32'({dout_a, dout_b, dout_c, dout_err}), 32'b1100);
        idle(2);

        // Parity error frame.
        send_frame(1, 0, 1, 0, 0, 1, 0);
        chk("err_word", 32'({dout_a, dout_b, dout_c, dout_err}), 32'b1101);
        idle(2);

        // Gapped slots, stray non-sof slot in IDLE.
        send_slot(1, 1'b0, 1);
        for (int g = 0; g < 4; g++) send_frame(1, 0, 1, 1, g, 1, 0);
        drain("gaps");

        // Early sof aborts a partial frame.
        e0 = err_seen;
        send_slot(1, 1'b1, 0);
        send_slot(0, 1'b0, 0);
        send_frame(0, 1, 1, 0, 0, 1, 0);
        idle(2);
        chk("err_sync_once", 32'(err_seen - e0), 32'd1);
        drain("sync");

        // Overflow: 6 frames into a 4-deep FIFO with no consumer.
        dout_rdy = 1'b0;
        o0 = ovf_seen;
        send_frame(0, 1, 0, 1, 0, 1, 0);
        send_frame(1, 1, 0, 0, 0, 1, 0);
        send_frame(0, 0, 1, 1, 0, 1, 0);
        send_frame(1, 0, 0, 0, 0, 1, 0);
        send_frame(1, 1, 1, 1, 0, 0, 0);
        send_frame(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        chk("ovf_pulses", 32'(ovf_seen - o0), 32'd2);
        chk("ovf_cnt2", 32'(ovf_cnt), 32'd2);
        chk("full_head", 32'({dout_vld, dout_a, dout_b, dout_c, dout_err}), 32'b11000);

        // Full FIFO with a pop on the P-slot cycle: no drop, still full after.
        o0 = ovf_seen;
        send_frame(1, 1, 1, 0, 0, 1, 1);
        idle(2);
        chk("pop_push_no_ovf", 32'(ovf_seen - o0), 32'd0);
        chk("pop_push_cnt", 32'(ovf_cnt), 32'd2);
        send_frame(0, 1, 1, 1, 0, 0, 0);
        idle(2);
        chk("still_full_ovf", 32'(ovf_cnt), 32'd3);
        drain("ovf");

        // Reset mid-frame with FIFO contents.
        send_frame(1, 0, 0, 1, 0, 1, 0);
        send_slot(1, 1'b1, 0);
        send_slot(0, 1'b0, 0);
        @(posedge clk); #1;
        sdi_vld = 1'b0;
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_vld", 32'(dout_vld), 32'd0);
        chk("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        // A lone non-sof slot must not be taken as the tail of the lost frame.
        send_slot(1, 1'b0, 0);
        send_frame(0, 1, 0, 0, 0, 1, 0);
        chk("post_rst_word", 32'({dout_vld, dout_a, dout_b, dout_c, dout_err}), 32'b11001);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
